// File: rtl/bounce_gen_if.sv
// Switch-emulator bus: requested level in, bouncing contact and status out.
// master drives the level, slave is the bounce generator.
interface bounce_gen_if;
    logic level_in;
    logic sw_out;
    logic busy;
    logic done;

    modport master (
        output level_in,
        input  sw_out,
        input  busy,
        input  done
    );

    modport slave (
        input  level_in,
        output sw_out,
        output busy,
        output done
    );
endinterface

// File: rtl/bounce_gen.sv
// Mechanical switch bounce emulator: odd toggle burst, then settle and pulse done.
// Define BOUNCE_GEN_RAND_EN to stretch each hold by a 16-bit LFSR sample.
module bounce_gen #(
    parameter int BOUNCES  = 2,
    parameter int MIN_HOLD = 4,
    parameter int SETTLE   = 8,
    parameter int HOLD_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    bounce_gen_if.slave bus
);

    localparam int TOTAL    = 2 * BOUNCES + 1;
    localparam int NW       = $clog2(TOTAL + 1);
    localparam int HOLD_MAX = MIN_HOLD + (1 << HOLD_W) - 1;
    localparam int T_MAX    = (HOLD_MAX > SETTLE) ? HOLD_MAX : SETTLE;
    localparam int CW       = $clog2(T_MAX + 1);

    localparam logic [CW-1:0] L_SETTLE = CW'(SETTLE - 1);
    localparam logic [NW-1:0] L_TOTAL  = NW'(TOTAL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BOUNCE,
        S_SETTLE
    } state_t;

    state_t        r_state;
    logic          r_sw;
    logic          r_busy;
    logic          r_done;
    logic          r_tgt;
    logic [NW-1:0] r_cnt;
    logic [CW-1:0] r_tmr;

    state_t        w_state;
    logic          w_sw;
    logic          w_busy;
    logic          w_done;
    logic          w_tgt;
    logic [NW-1:0] w_cnt;
    logic [CW-1:0] w_tmr;
    logic [CW-1:0] w_hold;

`ifdef BOUNCE_GEN_RAND_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign w_hold = CW'(MIN_HOLD - 1) + CW'(r_lfsr[HOLD_W-1:0]);
`else
    assign w_hold = CW'(MIN_HOLD - 1);
`endif

    // Timers hold "cycles remaining minus one" so zero means act this edge.
    always_comb begin
        w_state = r_state;
        w_sw    = r_sw;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_tgt   = r_tgt;
        w_cnt   = r_cnt;
        w_tmr   = r_tmr;
        unique case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.level_in != r_sw) begin
                    w_tgt  = bus.level_in;
                    w_sw   = ~r_sw;
                    w_cnt  = NW'(1);
                    w_busy = 1'b1;
                    if (TOTAL == 1) begin
                        w_state = S_SETTLE;
                        w_tmr   = L_SETTLE;
                    end else begin
                        w_state = S_BOUNCE;
                        w_tmr   = w_hold;
                    end
                end
            end
            S_BOUNCE: begin
                if (r_tmr == '0) begin
                    w_cnt = r_cnt + NW'(1);
                    if (r_cnt + NW'(1) == L_TOTAL) begin
                        w_sw    = r_tgt;
                        w_state = S_SETTLE;
                        w_tmr   = L_SETTLE;
                    end else begin
                        w_sw  = ~r_sw;
                        w_tmr = w_hold;
                    end
                end else begin
                    w_tmr = r_tmr - CW'(1);
                end
            end
            S_SETTLE: begin
                if (r_tmr == '0) begin
                    w_state = S_IDLE;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_cnt   = '0;
                end else begin
                    w_tmr = r_tmr - CW'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_sw    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_tgt   <= 1'b0;
            r_cnt   <= '0;
            r_tmr   <= '0;
        end else begin
            r_state <= w_state;
            r_sw    <= w_sw;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_tgt   <= w_tgt;
            r_cnt   <= w_cnt;
            r_tmr   <= w_tmr;
        end
    end

    assign bus.sw_out = r_sw;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;

endmodule
